// File: rtl/alu32_pipe_if.sv
// rtl/alu32_pipe_if.sv - request/result channel bundle for the pipelined 32-bit ALU
interface alu32_pipe_if #(
  parameter int TAG_W = 4
);
  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_f;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic             out_zero;
  logic             out_overflow;
  logic             out_negative;
  logic             out_carry;
  logic [TAG_W-1:0] out_tag;

  // The ALU responds to requests and produces results
  modport slave (
    input  in_valid, in_f, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_overflow,
           out_negative, out_carry, out_tag
  );

  // Issuer / consumer side
  modport master (
    output in_valid, in_f, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_overflow,
           out_negative, out_carry, out_tag
  );
endinterface

// File: rtl/alu32_pipe.sv
// rtl/alu32_pipe.sv - two-stage handshaked 32-bit add/sub/and/or ALU (optional ALU_PIPE_STATS_EN counters)
module alu32_pipe #(
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  alu32_pipe_if.slave bus
`ifdef ALU_PIPE_STATS_EN
  ,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_ovf
`endif
);

  // Stage 1: captured request
  logic             s1_valid_q;
  logic [1:0]       s1_f_q;
  logic [31:0]      s1_a_q;
  logic [31:0]      s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2: computed result
  logic             s2_valid_q;
  logic [31:0]      s2_y_q;
  logic             s2_zero_q;
  logic             s2_ovf_q;
  logic             s2_neg_q;
  logic             s2_carry_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Result of stage 1 operands, loaded into stage 2
  logic [31:0]      s2_y_d;
  logic             s2_ovf_d;
  logic             s2_carry_d;
  logic [31:0]      b_op;
  logic [32:0]      sum;

  logic s2_adv;
  logic s1_adv;

  // Advance conditions depend only on registered valids and the consumer's ready
  assign s2_adv = !s2_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1 register: take a new request whenever the stage can move
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_f_q     <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_f_q   <= bus.in_f;
        s1_a_q   <= bus.in_a;
        s1_b_q   <= bus.in_b;
        s1_tag_q <= bus.in_tag;
      end
    end
  end

  // ALU datapath: subtraction reuses the adder as A + ~B + 1
  always_comb begin
    s2_y_d     = '0;
    s2_ovf_d   = 1'b0;
    s2_carry_d = 1'b0;
    b_op       = s1_f_q[0] ? ~s1_b_q : s1_b_q;
    sum        = {1'b0, s1_a_q} + {1'b0, b_op} + {32'd0, s1_f_q[0]};
    case (s1_f_q)
      2'b00, 2'b01: begin
        s2_y_d     = sum[31:0];
        s2_carry_d = sum[32];
        // For sub, b_op[31] is ~B[31], so this covers both add and sub rules
        s2_ovf_d   = (s1_a_q[31] == b_op[31]) && (sum[31] != s1_a_q[31]);
      end
      2'b10:   s2_y_d = s1_a_q & s1_b_q;
      default: s2_y_d = s1_a_q | s1_b_q;
    endcase
  end

  // Stage 2 register: output data is held after a transfer, only valid drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_carry_q <= 1'b0;
      s2_tag_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_y_q     <= s2_y_d;
        s2_zero_q  <= (s2_y_d == 32'd0);
        s2_ovf_q   <= s2_ovf_d;
        s2_neg_q   <= s2_y_d[31];
        s2_carry_q <= s2_carry_d;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  assign bus.out_valid    = s2_valid_q;
  assign bus.out_y        = s2_y_q;
  assign bus.out_zero     = s2_zero_q;
  assign bus.out_overflow = s2_ovf_q;
  assign bus.out_negative = s2_neg_q;
  assign bus.out_carry    = s2_carry_q;
  assign bus.out_tag      = s2_tag_q;

`ifdef ALU_PIPE_STATS_EN
  logic [31:0] stat_ops_q;
  logic [31:0] stat_ovf_q;

  // Count completed result transfers and those flagged as overflowing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (s2_valid_q && bus.out_ready) begin
      stat_ops_q <= stat_ops_q + 32'd1;
      if (s2_ovf_q) begin
        stat_ovf_q <= stat_ovf_q + 32'd1;
      end
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_alu32_pipe.sv
// tb/tb_alu32_pipe.sv - scoreboard bench for alu32_pipe
module tb_alu32_pipe;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu32_pipe_if #(.TAG_W(TAG_W)) bus ();

`ifdef ALU_PIPE_STATS_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_ovf;
`endif

  alu32_pipe #(.TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ALU_PIPE_STATS_EN
    ,
    .stat_ops(stat_ops),
    .stat_ovf(stat_ovf)
`endif
  );

  typedef struct packed {
    logic [31:0]      y;
    logic             z;
    logic             v;
    logic             n;
    logic             c;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  logic [31:0] m_ops = 0;
  logic [31:0] m_ovf = 0;
  res_t        cur;
  res_t        prev_out;
  res_t        e;
  logic        prev_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Reference model using wide signed/unsigned arithmetic
  function automatic res_t model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag);
    res_t   r;
    longint sa, sb, s, lim;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    lim = 64'sd2147483648;
    r   = '0;
    case (f)
      2'd0: begin
        r.y = a + b;
        r.c = ((ua + ub) >> 32) != 64'd0;
        s   = sa + sb;
        r.v = (s >= lim) || (s < -lim);
      end
      2'd1: begin
        r.y = a - b;
        r.c = (a >= b);
        s   = sa - sb;
        r.v = (s >= lim) || (s < -lim);
      end
      2'd2: r.y = a & b;
      default: r.y = a | b;
    endcase
    r.z   = (r.y == 32'd0);
    r.n   = r.y[31];
    r.tag = tag;
    return r;
  endfunction

  // Monitor: handshake, ordering, stall stability and counter checks away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {bus.out_y, bus.out_zero, bus.out_overflow, bus.out_negative, bus.out_carry, bus.out_tag};
      chk("in_ready", 64'(bus.in_ready), 64'(!(exp_q.size() == 2 && !bus.out_ready)));
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_hold", 64'(cur), 64'(prev_out));
      end
`ifdef ALU_PIPE_STATS_EN
      chk("stat_ops", 64'(stat_ops), 64'(m_ops));
      chk("stat_ovf", 64'(stat_ovf), 64'(m_ovf));
`endif
      if (bus.out_valid && bus.out_ready) begin
        chk("queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", 64'(cur), 64'(e));
          pops++;
          m_ops = m_ops + 32'd1;
          if (e.v) m_ovf = m_ovf + 32'd1;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_f, bus.in_a, bus.in_b, bus.in_tag));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = cur;
    end
  end

  task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    logic acc;
    bus.in_f = f; bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    m_ops = 0;
    m_ovf = 0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sf[8];
    logic [31:0] sa[8];
    logic [31:0] sb[8];
    int i, k, p0;
    logic acc, saw;

    bus.in_valid = 1'b0; bus.in_f = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_y", 64'(bus.out_y), 64'(0));
    chk("rst_flags", 64'({bus.out_zero, bus.out_overflow, bus.out_negative, bus.out_carry}), 64'(0));
    chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Add with overflow, latency check
    bus.in_f = 2'b00; bus.in_a = 32'h7FFF_FFFF; bus.in_b = 32'h0000_0001; bus.in_tag = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("lat_edge_n", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("lat_edge_n1", 64'(bus.out_valid), 64'(1));
    chk("add_y", 64'(bus.out_y), 64'(32'h8000_0000));
    chk("add_flags_zvnc", 64'({bus.out_zero, bus.out_overflow, bus.out_negative, bus.out_carry}), 64'(4'b0110));
    chk("add_tag", 64'(bus.out_tag), 64'(3));
    @(posedge clk);
    #1;
    chk("add_done", 64'(bus.out_valid), 64'(0));

    // Sub to zero, sub with borrow
    send(2'b01, 32'd5, 32'd5, 4'd1);
    drain();
    chk("sub0_y", 64'(bus.out_y), 64'(0));
    chk("sub0_flags_zvnc", 64'({bus.out_zero, bus.out_overflow, bus.out_negative, bus.out_carry}), 64'(4'b1001));
    send(2'b01, 32'd0, 32'd1, 4'd2);
    drain();
    chk("sub1_y", 64'(bus.out_y), 64'(32'hFFFF_FFFF));
    chk("sub1_flags_zvnc", 64'({bus.out_zero, bus.out_overflow, bus.out_negative, bus.out_carry}), 64'(4'b0010));

    // Logic ops
    send(2'b10, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd4);
    drain();
    chk("and_y", 64'(bus.out_y), 64'(32'hF0F0_0000));
    chk("and_flags_zvnc", 64'({bus.out_zero, bus.out_overflow, bus.out_negative, bus.out_carry}), 64'(4'b0010));
    send(2'b11, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd5);
    drain();
    chk("or_y", 64'(bus.out_y), 64'(32'hFFFF_F0F0));
    chk("or_tag", 64'(bus.out_tag), 64'(5));

    // Backpressure stream: 8 ops, out_ready pattern 1,0,0,1
    for (int j = 0; j < 8; j++) begin
      sf[j] = 2'($urandom_range(3));
      sa[j] = $urandom;
      sb[j] = $urandom;
    end
    i = 0; k = 0; p0 = pops; saw = 1'b0;
    while ((i < 8 || exp_q.size() != 0) && k < 200) begin
      bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
      bus.in_valid  = (i < 8);
      if (i < 8) begin
        bus.in_f = sf[i]; bus.in_a = sa[i]; bus.in_b = sb[i]; bus.in_tag = 4'(i);
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) saw = 1'b1;
      @(posedge clk);
      #1;
      if (acc) i++;
      k++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_issued", 64'(i), 64'(8));
    chk("stream_count", 64'(pops - p0), 64'(8));
    chk("stream_saw_full", 64'(saw), 64'(1));

    // Reset with two ops in flight
    bus.out_ready = 1'b0;
    send(2'b00, 32'd10, 32'd20, 4'd6);
    send(2'b01, 32'd30, 32'd4, 4'd7);
    chk("inflight_valid", 64'(bus.out_valid), 64'(1));
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    m_ops = 0;
    m_ovf = 0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("async_rst_y", 64'(bus.out_y), 64'(0));
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale", 64'(bus.out_valid), 64'(0));
    send(2'b00, 32'h0000_1234, 32'd1, 4'd9);
    drain();
    chk("post_rst_y", 64'(bus.out_y), 64'(32'h0000_1235));
    chk("post_rst_tag", 64'(bus.out_tag), 64'(9));

`ifdef ALU_PIPE_STATS_EN
    pulse_reset();
    chk("stat_rst", 64'(stat_ops), 64'(0));
    bus.out_ready = 1'b0;
    send(2'b00, 32'h7FFF_FFFF, 32'd1, 4'd1);
    send(2'b01, 32'h8000_0000, 32'd1, 4'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("stat_stall_ops", 64'(stat_ops), 64'(0));
    drain();
    send(2'b00, 32'd1, 32'd2, 4'd3);
    send(2'b10, 32'd3, 32'd1, 4'd4);
    send(2'b11, 32'd8, 32'd1, 4'd5);
    drain();
    @(posedge clk);
    #1;
    chk("stat_ops_final", 64'(stat_ops), 64'(5));
    chk("stat_ovf_final", 64'(stat_ovf), 64'(2));
`endif

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
